// File: rtl/systolic_pkg.sv
// Shared types and sizing for the systolic array sequencer.
package systolic_pkg;

    localparam int N  = 3;
    localparam int DW = 16;
    localparam int AW = (N > 1) ? $clog2(N) : 1;

    typedef logic [DW-1:0]                 operand_t;
    typedef logic [N-1:0][DW-1:0]          row_t;
    typedef logic [N-1:0][N-1:0][DW-1:0]   matrix_t;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        READ
    } seq_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/systolic_seq_if.sv
// Host-side config and start/done handshake of the systolic sequencer.
interface systolic_seq_if;

    logic                          cfg_we;
    logic                          cfg_sel;
    logic [2*systolic_pkg::AW-1:0] cfg_addr;
    systolic_pkg::operand_t        cfg_wdata;
    logic                          start;
    logic                          busy;
    logic                          done;

    modport master (
        output cfg_we, cfg_sel, cfg_addr, cfg_wdata, start,
        input  busy, done
    );

    modport slave (
        input  cfg_we, cfg_sel, cfg_addr, cfg_wdata, start,
        output busy, done
    );

endinterface

// File: rtl/systolic_skew_mux.sv
// Picks the diagonally skewed left/top operands for feed step k.
module systolic_skew_mux
    import systolic_pkg::*;
#(
    parameter int KW = 3
) (
    input  logic [KW-1:0] k,
    input  row_t          l_d,
    input  matrix_t       t_d,
    output operand_t      l_out,
    output row_t          t_out
);

    // Column j sees its weight column delayed by j steps: element i appears at k = j + i.
    always_comb begin
        l_out = '0;
        t_out = '0;
        for (int i = 0; i < N; i++) begin
            if (int'(k) == i) begin
                l_out = l_d[i];
            end
        end
        for (int j = 0; j < N; j++) begin
            for (int i = 0; i < N; i++) begin
                if (int'(k) == j + i) begin
                    t_out[j] = t_d[j][i];
                end
            end
        end
    end

endmodule

// File: rtl/systolic_seq.sv
// Sequencer for the N x N systolic array: clear, skewed feed, drain, read.
module systolic_seq
    import systolic_pkg::*;
#(
    parameter int CLR_CYC   = 3,
    parameter int DRAIN_CYC = 3
) (
    input  logic          clk,
    input  logic          reset,
    systolic_seq_if.slave host,
    output logic          sa_reset,
    output operand_t      sa_l_d_i,
    output row_t          sa_pe_t_w,
    output logic          sa_read
);

    localparam int KW = $clog2(max3(2 * N - 1, CLR_CYC, DRAIN_CYC) + 1);
    localparam logic [KW-1:0] CLR_LAST   = KW'(CLR_CYC - 1);
    localparam logic [KW-1:0] FEED_LAST  = KW'(2 * N - 2);
    localparam logic [KW-1:0] DRAIN_LAST = KW'(DRAIN_CYC - 1);

    seq_state_t    state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    row_t          l_d_q, l_d_d;
    matrix_t       t_d_q, t_d_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          sa_reset_q, sa_reset_d;
    logic          sa_read_q, sa_read_d;
    operand_t      sa_l_d_i_q, sa_l_d_i_d;
    row_t          sa_pe_t_w_q, sa_pe_t_w_d;
    operand_t      mux_l;
    row_t          mux_t;
    logic [AW-1:0] addr_lo;
    logic [AW-1:0] addr_hi;

    assign addr_lo = host.cfg_addr[AW-1:0];
    assign addr_hi = host.cfg_addr[2*AW-1:AW];

    // Out-of-range indices simply never match a storage slot.
    always_comb begin
        l_d_d = l_d_q;
        t_d_d = t_d_q;
        if (host.cfg_we && !busy_q) begin
            for (int i = 0; i < N; i++) begin
                if (!host.cfg_sel && int'(addr_lo) == i) begin
                    l_d_d[i] = host.cfg_wdata;
                end
            end
            for (int j = 0; j < N; j++) begin
                for (int i = 0; i < N; i++) begin
                    if (host.cfg_sel && int'(addr_hi) == j && int'(addr_lo) == i) begin
                        t_d_d[j][i] = host.cfg_wdata;
                    end
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        case (state_q)
            IDLE: begin
                if (host.start) begin
                    state_d = CLEAR;
                    k_d     = '0;
                end
            end
            CLEAR: begin
                if (k_q == CLR_LAST) begin
                    state_d = FEED;
                    k_d     = '0;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            FEED: begin
                if (k_q == FEED_LAST) begin
                    state_d = (DRAIN_CYC == 0) ? READ : DRAIN;
                    k_d     = '0;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            DRAIN: begin
                if (k_q == DRAIN_LAST) begin
                    state_d = READ;
                    k_d     = '0;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            READ: begin
                state_d = IDLE;
                k_d     = '0;
            end
            default: begin
                state_d = IDLE;
                k_d     = '0;
            end
        endcase
    end

    systolic_skew_mux #(.KW(KW)) u_skew_mux (
        .k     (k_d),
        .l_d   (l_d_d),
        .t_d   (t_d_d),
        .l_out (mux_l),
        .t_out (mux_t)
    );

    // Outputs decode the next state so they line up with it once registered.
    always_comb begin
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == READ);
        sa_read_d   = (state_d == READ);
        sa_reset_d  = (state_d == CLEAR);
        sa_l_d_i_d  = (state_d == FEED) ? mux_l : '0;
        sa_pe_t_w_d = (state_d == FEED) ? mux_t : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            k_q         <= '0;
            l_d_q       <= '0;
            t_d_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sa_reset_q  <= 1'b1;
            sa_read_q   <= 1'b0;
            sa_l_d_i_q  <= '0;
            sa_pe_t_w_q <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            l_d_q       <= l_d_d;
            t_d_q       <= t_d_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            sa_reset_q  <= sa_reset_d;
            sa_read_q   <= sa_read_d;
            sa_l_d_i_q  <= sa_l_d_i_d;
            sa_pe_t_w_q <= sa_pe_t_w_d;
        end
    end

    assign host.busy = busy_q;
    assign host.done = done_q;
    assign sa_reset  = sa_reset_q;
    assign sa_read   = sa_read_q;
    assign sa_l_d_i  = sa_l_d_i_q;
    assign sa_pe_t_w = sa_pe_t_w_q;

endmodule

// File: tb/tb_systolic_seq.sv
// Scoreboard bench: a run-level reference model predicts every output cycle, a monitor compares.
module tb_systolic_seq;
    import systolic_pkg::*;

    localparam int CLR_CYC   = 3;
    localparam int DRAIN_CYC = 3;
    localparam int FEED_CYC  = 2 * N - 1;
    localparam int TOTAL     = CLR_CYC + FEED_CYC + DRAIN_CYC + 1;
    localparam int ADDR_W    = 2 * AW;

    typedef struct {
        logic     busy;
        logic     done;
        logic     sa_reset;
        logic     sa_read;
        operand_t l;
        row_t     t;
    } obs_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic     sa_reset;
    logic     sa_read;
    operand_t sa_l_d_i;
    row_t     sa_pe_t_w;

    systolic_seq_if host();

    systolic_seq #(.CLR_CYC(CLR_CYC), .DRAIN_CYC(DRAIN_CYC)) dut (
        .clk       (clk),
        .reset     (reset),
        .host      (host),
        .sa_reset  (sa_reset),
        .sa_l_d_i  (sa_l_d_i),
        .sa_pe_t_w (sa_pe_t_w),
        .sa_read   (sa_read)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int run_start   = 0;
    bit run_active  = 0;
    operand_t l_ref [N];
    operand_t t_ref [N][N];
    obs_t exp_q [$];

    function automatic obs_t reset_obs();
        obs_t o;
        o = '{default: '0};
        o.sa_reset = 1'b1;
        return o;
    endfunction

    // Reference model: a run is a fixed timeline measured from the edge start was taken.
    always @(posedge clk) begin
        obs_t e;
        int   t, s, lo, hi;
        e = '{default: '0};
        if (!reset) begin
            run_active = 0;
            for (int i = 0; i < N; i++) begin
                l_ref[i] = '0;
                for (int j = 0; j < N; j++) t_ref[i][j] = '0;
            end
            e = reset_obs();
        end else begin
            if (run_active && (cyc - run_start) > TOTAL) run_active = 0;
            if (host.cfg_we && !run_active) begin
                lo = int'(host.cfg_addr[AW-1:0]);
                hi = int'(host.cfg_addr[2*AW-1:AW]);
                if (!host.cfg_sel) begin
                    if (lo < N) l_ref[lo] = host.cfg_wdata;
                end else if (hi < N && lo < N) begin
                    t_ref[hi][lo] = host.cfg_wdata;
                end
            end
            if (host.start && !run_active) begin
                run_active = 1;
                run_start  = cyc;
            end
            t = cyc - run_start;
            if (run_active && t < TOTAL) begin
                e.busy = 1'b1;
                if (t < CLR_CYC) begin
                    e.sa_reset = 1'b1;
                end else if (t < CLR_CYC + FEED_CYC) begin
                    s = t - CLR_CYC;
                    if (s < N) e.l = l_ref[s];
                    for (int j = 0; j < N; j++) begin
                        if (s - j >= 0 && s - j < N) e.t[j] = t_ref[j][s - j];
                    end
                end else if (t == TOTAL - 1) begin
                    e.done    = 1'b1;
                    e.sa_read = 1'b1;
                end
            end
        end
        exp_q.push_back(e);
        cyc++;
    end

    task automatic check_output(input obs_t e, input obs_t a);
        vectors++;
        if (a.busy !== e.busy || a.done !== e.done || a.sa_reset !== e.sa_reset ||
            a.sa_read !== e.sa_read || a.l !== e.l || a.t !== e.t) begin
            miscompares++;
            $display("[TB] FAIL cycle%0d: got busy=%0b done=%0b rst=%0b rd=%0b l=%0d t=%h, want busy=%0b done=%0b rst=%0b rd=%0b l=%0d t=%h",
                     cyc, a.busy, a.done, a.sa_reset, a.sa_read, a.l, a.t,
                     e.busy, e.done, e.sa_reset, e.sa_read, e.l, e.t);
        end
    endtask

    // Monitor: an asynchronous reset overrides whatever the model predicted at the last edge.
    always @(negedge clk) begin
        obs_t e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (!reset) e = reset_obs();
            a.busy     = host.busy;
            a.done     = host.done;
            a.sa_reset = sa_reset;
            a.sa_read  = sa_read;
            a.l        = sa_l_d_i;
            a.t        = sa_pe_t_w;
            check_output(e, a);
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic sel, input int hi, input int lo, input int val);
        host.cfg_we    = 1'b1;
        host.cfg_sel   = sel;
        host.cfg_addr  = {AW'(hi), AW'(lo)};
        host.cfg_wdata = DW'(val);
        wait_cycles(1);
        host.cfg_we    = 1'b0;
    endtask

    task automatic pulse_start();
        host.start = 1'b1;
        wait_cycles(1);
        host.start = 1'b0;
    endtask

    task automatic load_reference();
        int lv [3] = '{8, 10, 4};
        int tv [3][3] = '{'{1, 7, 9}, '{6, 3, 5}, '{2, 7, 2}};
        for (int i = 0; i < 3; i++) cfg_write(1'b0, 0, i, lv[i]);
        for (int j = 0; j < 3; j++)
            for (int i = 0; i < 3; i++) cfg_write(1'b1, j, i, tv[j][i]);
    endtask

    initial begin
        host.cfg_we    = 1'b0;
        host.cfg_sel   = 1'b0;
        host.cfg_addr  = '0;
        host.cfg_wdata = '0;
        host.start     = 1'b0;
        wait_cycles(3);
        reset = 1'b1;
        wait_cycles(2);

        $display("[TB] reference run");
        load_reference();
        pulse_start();
        wait_cycles(TOTAL + 2);

        $display("[TB] write while busy");
        pulse_start();
        wait_cycles(CLR_CYC + 1);
        cfg_write(1'b0, 0, 0, 99);
        wait_cycles(TOTAL);
        pulse_start();
        wait_cycles(TOTAL + 1);
        cfg_write(1'b0, 0, 0, 99);
        pulse_start();
        wait_cycles(TOTAL + 1);
        cfg_write(1'b0, 0, 0, 8);

        $display("[TB] start during drain");
        pulse_start();
        wait_cycles(CLR_CYC + FEED_CYC);
        pulse_start();
        wait_cycles(TOTAL);

        $display("[TB] reset mid-run");
        pulse_start();
        wait_cycles(CLR_CYC + 2);
        reset = 1'b0;
        wait_cycles(2);
        reset = 1'b1;
        wait_cycles(1);
        load_reference();
        pulse_start();
        wait_cycles(TOTAL + 2);

        $display("[TB] back-to-back with start held");
        host.start = 1'b1;
        wait_cycles(3 * (TOTAL + 1));
        host.start = 1'b0;
        wait_cycles(TOTAL + 2);

        $display("[TB] out-of-range write");
        cfg_write(1'b1, 3, 1, 555);
        cfg_write(1'b0, 0, 3, 777);
        pulse_start();
        wait_cycles(TOTAL + 2);

        $display("[TB] randomized traffic");
        for (int c = 0; c < 400; c++) begin
            host.cfg_we    = 1'($urandom_range(0, 1));
            host.cfg_sel   = 1'($urandom_range(0, 1));
            host.cfg_addr  = ADDR_W'($urandom);
            host.cfg_wdata = DW'($urandom);
            host.start     = ($urandom_range(0, 9) == 0);
            wait_cycles(1);
        end
        host.cfg_we = 1'b0;
        host.start  = 1'b0;
        wait_cycles(TOTAL + 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
